// File: rtl/i2c_pkg.sv
`timescale 1ns/1ps
// rtl/i2c_pkg.sv - shared I2C target types and constants (I2C_READ_EN adds the read states)
package i2c_pkg;

   localparam int   BYTE_W = 8;
   localparam logic ACK    = 1'b0;
   localparam logic NACK   = 1'b1;

   typedef enum logic [3:0] {
      IDLE,
      ADDR,
      ADDR_ACK,
      SUB,
      SUB_ACK,
      DATA,
      DATA_ACK,
`ifdef I2C_READ_EN
      RD_BYTE,
      RD_ACK,
`endif
      IGNORE
   } state_t;

endpackage

// File: rtl/i2c_target_rx_if.sv
`timescale 1ns/1ps
// rtl/i2c_target_rx_if.sv - register-write side of the I2C target (RD_DATA only with I2C_READ_EN)
interface i2c_target_rx_if;
   import i2c_pkg::*;

   logic [BYTE_W-1:0] REG_ADDR;
   logic [BYTE_W-1:0] REG_DATA;
   logic              REG_WE;
   logic              BUSY;
`ifdef I2C_READ_EN
   logic [BYTE_W-1:0] RD_DATA;
`endif

   modport master (
      output REG_ADDR,
      output REG_DATA,
      output REG_WE,
`ifdef I2C_READ_EN
      input  RD_DATA,
`endif
      output BUSY
   );

   modport slave (
      input  REG_ADDR,
      input  REG_DATA,
      input  REG_WE,
`ifdef I2C_READ_EN
      output RD_DATA,
`endif
      input  BUSY
   );

endinterface

// File: rtl/i2c_bus_sync.sv
`timescale 1ns/1ps
// rtl/i2c_bus_sync.sv - SCL/SDA synchroniser with SCL edge and START/STOP pulse detection
module i2c_bus_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic CLOCK,
   input  logic RESET,
   input  logic scl_in,
   input  logic sda_in,
   output logic sda_s,
   output logic scl_rise,
   output logic scl_fall,
   output logic start,
   output logic stop
);

   logic [SYNC_STAGES-1:0] scl_ff;
   logic [SYNC_STAGES-1:0] sda_ff;
   logic                   scl_d;
   logic                   sda_d;
   logic                   scl_s;

   // Idle bus is high on both lines, so reset to 1 to avoid a fake edge on release.
   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
         scl_ff <= '1;
         sda_ff <= '1;
         scl_d  <= 1'b1;
         sda_d  <= 1'b1;
      end else begin
         scl_ff <= {scl_ff[SYNC_STAGES-2:0], scl_in};
         sda_ff <= {sda_ff[SYNC_STAGES-2:0], sda_in};
         scl_d  <= scl_ff[SYNC_STAGES-1];
         sda_d  <= sda_ff[SYNC_STAGES-1];
      end
   end

   assign scl_s    = scl_ff[SYNC_STAGES-1];
   assign sda_s    = sda_ff[SYNC_STAGES-1];
   assign scl_rise =  scl_s & ~scl_d;
   assign scl_fall = ~scl_s &  scl_d;
   assign start    =  scl_s & scl_d &  sda_d & ~sda_s;
   assign stop     =  scl_s & scl_d & ~sda_d &  sda_s;

endmodule

// File: rtl/i2c_target_rx.sv
`timescale 1ns/1ps
// rtl/i2c_target_rx.sv - I2C target receiver: address match, ACK, register-write strobes (I2C_READ_EN adds reads)
module i2c_target_rx
   import i2c_pkg::*;
#(
   parameter logic [6:0] DEV_ADDR    = 7'h1A,
   parameter int         SYNC_STAGES = 2
) (
   input  logic CLOCK,
   input  logic RESET,
   input  logic I2C_SCLK,
   inout  wire  I2C_SDAT,
   i2c_target_rx_if.master regs
);

   logic              sda_s;
   logic              scl_rise;
   logic              scl_fall;
   logic              start;
   logic              stop;

   state_t            state;
   logic [2:0]        bit_cnt;
   logic [BYTE_W-2:0] shift;
   logic [BYTE_W-1:0] rx_byte;
   logic [BYTE_W-1:0] sub_addr;
   logic [BYTE_W-1:0] reg_addr_q;
   logic [BYTE_W-1:0] reg_data_q;
   logic              reg_we_q;
   logic              busy_q;
   logic              sda_q;
   logic              ack_hold;
`ifdef I2C_READ_EN
   logic              rd_mode;
   logic [BYTE_W-2:0] rd_shift;
`endif

   i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .CLOCK    (CLOCK),
      .RESET    (RESET),
      .scl_in   (I2C_SCLK),
      .sda_in   (I2C_SDAT),
      .sda_s    (sda_s),
      .scl_rise (scl_rise),
      .scl_fall (scl_fall),
      .start    (start),
      .stop     (stop)
   );

   assign rx_byte       = {shift, sda_s};
   assign I2C_SDAT      = (sda_q == ACK) ? 1'b0 : 1'bz;
   assign regs.REG_ADDR = reg_addr_q;
   assign regs.REG_DATA = reg_data_q;
   assign regs.REG_WE   = reg_we_q;
   assign regs.BUSY     = busy_q;

   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
         state      <= IDLE;
         bit_cnt    <= 3'd0;
         shift      <= '0;
         sub_addr   <= '0;
         reg_addr_q <= '0;
         reg_data_q <= '0;
         reg_we_q   <= 1'b0;
         busy_q     <= 1'b0;
         sda_q      <= NACK;
         ack_hold   <= 1'b0;
`ifdef I2C_READ_EN
         rd_mode    <= 1'b0;
         rd_shift   <= '0;
`endif
      end else begin
         reg_we_q <= 1'b0;
         if (stop) begin
            state    <= IDLE;
            busy_q   <= 1'b0;
            sda_q    <= NACK;
            bit_cnt  <= 3'd0;
            ack_hold <= 1'b0;
         end else if (start) begin
            state    <= ADDR;
            sda_q    <= NACK;
            bit_cnt  <= 3'd0;
            ack_hold <= 1'b0;
         end else begin
            case (state)
               ADDR, SUB, DATA: begin
                  if (scl_rise) begin
                     shift <= rx_byte[BYTE_W-2:0];
                     if (bit_cnt == 3'd7) begin
                        bit_cnt  <= 3'd0;
                        ack_hold <= 1'b0;
                        if (state == ADDR) begin
                           if (rx_byte[7:1] == DEV_ADDR && rx_byte[0] == 1'b0) begin
                              state  <= ADDR_ACK;
                              busy_q <= 1'b1;
`ifdef I2C_READ_EN
                              rd_mode <= 1'b0;
                           end else if (rx_byte[7:1] == DEV_ADDR) begin
                              state   <= ADDR_ACK;
                              busy_q  <= 1'b1;
                              rd_mode <= 1'b1;
`endif
                           end else begin
                              state <= IGNORE;
                           end
                        end else if (state == SUB) begin
                           sub_addr <= rx_byte;
                           state    <= SUB_ACK;
                        end else begin
                           reg_we_q   <= 1'b1;
                           reg_addr_q <= sub_addr;
                           reg_data_q <= rx_byte;
                           sub_addr   <= sub_addr + 8'd1;
                           state      <= DATA_ACK;
                        end
                     end else begin
                        bit_cnt <= bit_cnt + 3'd1;
                     end
                  end
               end
               // ACK is held from the fall after bit 8 through the fall after the 9th clock.
               ADDR_ACK, SUB_ACK, DATA_ACK: begin
                  if (scl_fall) begin
                     if (!ack_hold) begin
                        sda_q    <= ACK;
                        ack_hold <= 1'b1;
                     end else begin
                        sda_q    <= NACK;
                        ack_hold <= 1'b0;
                        if (state == ADDR_ACK) begin
`ifdef I2C_READ_EN
                           if (rd_mode) begin
                              state    <= RD_BYTE;
                              sda_q    <= regs.RD_DATA[7];
                              rd_shift <= regs.RD_DATA[6:0];
                           end else begin
                              state <= SUB;
                           end
`else
                           state <= SUB;
`endif
                        end else begin
                           state <= DATA;
                        end
                     end
                  end
               end
`ifdef I2C_READ_EN
               RD_BYTE: begin
                  if (scl_fall) begin
                     if (bit_cnt == 3'd7) begin
                        bit_cnt  <= 3'd0;
                        sda_q    <= NACK;
                        ack_hold <= 1'b0;
                        state    <= RD_ACK;
                     end else begin
                        bit_cnt  <= bit_cnt + 3'd1;
                        sda_q    <= rd_shift[6];
                        rd_shift <= {rd_shift[5:0], 1'b0};
                     end
                  end
               end
               RD_ACK: begin
                  if (scl_rise) begin
                     if (sda_s == ACK) ack_hold <= 1'b1;
                     else              state    <= IGNORE;
                  end else if (scl_fall && ack_hold) begin
                     ack_hold <= 1'b0;
                     state    <= RD_BYTE;
                     sda_q    <= regs.RD_DATA[7];
                     rd_shift <= regs.RD_DATA[6:0];
                  end
               end
`endif
               default: begin
               end
            endcase
         end
      end
   end

endmodule
